mem_access_unit: RTL and testbench

- Memory-side sequencer for the multicycle processor. Sits directly upstream of the single-port synchronous main memory (1024 x 32, word-addressed, one-cycle read latency).
- Accepts instruction-fetch, load and store requests from the datapath/control unit, drives the memory read/write/address/data lines, and captures returned words into the instruction register (IR) or the memory data register (MDR).
- Serialises all traffic onto the single memory port and signals completion with a one-cycle done pulse.

---
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Sequencer for the single-port main memory: serialises fetch/load/store onto the port and
// captures read data into IR/MDR. Define MEM_ADDR_CHECK_EN to flag out-of-range addresses.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       pc,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_ADDR_CHECK_EN
    localparam bit CheckEn = 1'b1;
`else
    localparam bit CheckEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;
    typedef enum logic [1:0] {KindFetch, KindLoad, KindStore} kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic              err_q, err_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              done_q, done_d;
    logic              addr_err_q, addr_err_d;
    logic [31:0]       sel_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            kind_q      <= KindFetch;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ir_q        <= '0;
            mdr_q       <= '0;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            done_q      <= done_d;
            addr_err_q  <= addr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        done_d      = 1'b0;
        addr_err_d  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        sel_addr    = addr;

        case (state_q)
            StIdle: begin
                if (fetch_req || ld_req || st_req) begin
                    // Priority fetch > load > store; losers keep requesting.
                    if (fetch_req) begin
                        kind_d   = KindFetch;
                        sel_addr = pc;
                    end else if (ld_req) begin
                        kind_d = KindLoad;
                    end else begin
                        kind_d = KindStore;
                    end
                    mem_addr_d  = {{(32 - ADDR_W){1'b0}}, sel_addr[ADDR_W-1:0]};
                    mem_wdata_d = st_data;
                    err_d       = CheckEn && (sel_addr[31:ADDR_W] != '0);
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (err_q) begin
                    // Out-of-range: skip the memory access entirely.
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    addr_err_d = 1'b1;
                end else if (kind_q == KindStore) begin
                    mem_write = 1'b1;
                    state_d   = StIdle;
                    done_d    = 1'b1;
                end else begin
                    mem_read = 1'b1;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                if (kind_q == KindFetch) begin
                    ir_d = mem_rdata;
                end else begin
                    mdr_d = mem_rdata;
                end
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign addr_err  = addr_err_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised self-checking bench for mem_access_unit with a behavioural memory and a
// transaction-level reference model.
module tb_mem_access_unit;
    localparam int unsigned AddrW = 10;
    localparam int unsigned DataW = 32;
    localparam int unsigned Depth = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fetch_req, ld_req, st_req;
    logic [31:0]      pc, addr;
    logic [DataW-1:0] st_data;
    logic             busy, done, addr_err, mem_read, mem_write;
    logic [DataW-1:0] ir, mdr, mem_wdata, mem_rdata;
    logic [31:0]      mem_addr;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AddrW), .DATA_W(DataW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_req (fetch_req),
        .pc        (pc),
        .ld_req    (ld_req),
        .st_req    (st_req),
        .addr      (addr),
        .st_data   (st_data),
        .busy      (busy),
        .done      (done),
        .addr_err  (addr_err),
        .ir        (ir),
        .mdr       (mdr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port synchronous memory with one-cycle read latency and a preload port.
    logic [DataW-1:0] mem [Depth];
    logic             pl_we;
    logic [9:0]       pl_addr;
    logic [DataW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[9:0]];
    end

    int unsigned      total = 0;
    int unsigned      bad = 0;
    logic [DataW-1:0] ref_mem [Depth];
    logic [DataW-1:0] exp_ir, exp_mdr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request set presented for a single cycle from idle; observes six cycles afterwards.
    task automatic run_txn(input bit f, input bit l, input bit s, input logic [31:0] pcv,
                           input logic [31:0] adv, input logic [31:0] dv, input bit toggle);
        bit          is_fetch, is_store, err;
        logic [31:0] full, a, saddr, sdata;
        int          done_at, reads, writes, dones, both, errs, busy_cnt, exp_done_at;
        is_fetch = f;
        is_store = !f && !l && s;
        full     = is_fetch ? pcv : adv;
        a        = full % Depth;
`ifdef MEM_ADDR_CHECK_EN
        err = (full >= Depth);
`else
        err = 1'b0;
`endif
        done_at = 0; reads = 0; writes = 0; dones = 0; both = 0; errs = 0; busy_cnt = 0;
        saddr = '0; sdata = '0;
        @(negedge clk);
        fetch_req = f; ld_req = l; st_req = s; pc = pcv; addr = adv; st_data = dv;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (mem_read) begin reads++; saddr = mem_addr; end
            if (mem_write) begin writes++; saddr = mem_addr; sdata = mem_wdata; end
            if (mem_read && mem_write) both++;
            if (done) begin
                dones++;
                if (done_at == 0) done_at = k;
                if (addr_err) errs++;
            end
            if (k == 1) begin fetch_req = toggle; ld_req = 1'b0; st_req = 1'b0; end
            if (k == 2) fetch_req = 1'b0;
        end
        exp_done_at = (err || is_store) ? 2 : 3;
        check_eq("done_latency", 32'(done_at), 32'(exp_done_at));
        check_eq("done_pulses", 32'(dones), 32'd1);
        check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_done_at - 1));
        check_eq("read_strobes", 32'(reads), 32'(!err && !is_store));
        check_eq("write_strobes", 32'(writes), 32'(!err && is_store));
        check_eq("strobe_overlap", 32'(both), 32'd0);
        check_eq("addr_err", 32'(errs), 32'(err));
        if (reads + writes == 1) check_eq("mem_addr", saddr, a);
        if (writes == 1) check_eq("mem_wdata", sdata, dv);
        if (!err) begin
            if (is_store) ref_mem[a] = dv;
            else if (is_fetch) exp_ir = ref_mem[a];
            else exp_mdr = ref_mem[a];
        end
        check_eq("ir", ir, exp_ir);
        check_eq("mdr", mdr, exp_mdr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          f, l, s, tg;
        logic [31:0] pv, av, dv;
        fetch_req = 0; ld_req = 0; st_req = 0; pc = '0; addr = '0; st_data = '0;
        pl_we = 0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = 10'(i);
            pl_data = (i == 5) ? 32'h8C22_0004 : (i == 1) ? 32'h1234_5678 : $urandom();
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_strobes", 32'({mem_read, mem_write, addr_err}), 32'd0);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_mdr", mdr, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        exp_ir = '0;
        exp_mdr = '0;

        run_txn(1, 0, 0, 32'd5, 32'd0, 32'd0, 0);
        run_txn(0, 0, 1, 32'd0, 32'h10, 32'hDEAD_BEEF, 0);
        run_txn(0, 1, 0, 32'd0, 32'h10, 32'd0, 0);

        // Fetch and load together: load is taken in the fetch's done cycle.
        @(negedge clk);
        fetch_req = 1; ld_req = 1; pc = 32'd1; addr = 32'd2;
        @(negedge clk);
        fetch_req = 0;
        check_eq("b2b_fetch_rd", 32'(mem_read), 32'd1);
        check_eq("b2b_fetch_addr", mem_addr, 32'd1);
        @(negedge clk);
        @(negedge clk);
        exp_ir = ref_mem[1];
        check_eq("b2b_fetch_done", 32'({done, busy}), 32'b10);
        check_eq("b2b_ir", ir, exp_ir);
        @(negedge clk);
        ld_req = 0;
        check_eq("b2b_load_rd", 32'({busy, mem_read}), 32'b11);
        check_eq("b2b_load_addr", mem_addr, 32'd2);
        @(negedge clk);
        @(negedge clk);
        exp_mdr = ref_mem[2];
        check_eq("b2b_load_done", 32'(done), 32'd1);
        check_eq("b2b_mdr", mdr, exp_mdr);

        // Reset during the issue cycle of a store.
        @(negedge clk);
        st_req = 1; addr = 32'd7; st_data = ~ref_mem[7];
        @(negedge clk);
        st_req = 0;
        check_eq("abort_pre_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_write", 32'(mem_write), 32'd0);
        check_eq("abort_busy_done", 32'({busy, done, addr_err, mem_read}), 32'd0);
        check_eq("abort_regs", ir | mdr | mem_addr | mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_ir = '0;
        exp_mdr = '0;
        check_eq("abort_mem7", mem[7], ref_mem[7]);
        check_eq("abort_idle", 32'(busy), 32'd0);
        run_txn(0, 1, 0, 32'd0, 32'd7, 32'd0, 0);

        run_txn(0, 1, 0, 32'd0, 32'h401, 32'd0, 0);
        run_txn(0, 1, 0, 32'd9, 32'd3, 32'd0, 1);

        for (int n = 0; n < 40; n++) begin
            f  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            if (!(f || l || s)) s = 1'b1;
            pv = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
            av = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
            dv = $urandom();
            tg = 1'($urandom_range(0, 1));
            run_txn(f, l, s, pv, av, dv, tg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
